// File: rtl/alu_arbiter_pkg.sv
// Shared constants and FSM encoding for the ALU arbiter and its ALU.
package alu_arbiter_pkg;
  localparam int   ALU_W      = 16;
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;
endpackage

// File: rtl/alu_component.sv
// 16-bit add/subtract unit with zero/positive flags; reset forces a quiet zero result.
module alu_component
  import alu_arbiter_pkg::*;
(
  input  logic             reset,
  input  logic             op,
  input  logic [ALU_W-1:0] in0,
  input  logic [ALU_W-1:0] in1,
  output logic [ALU_W-1:0] out,
  output logic             zero,
  output logic             pos
);
  always_comb begin
    out = '0;
    if (!reset) out = (op == ALU_OP_SUB) ? (in0 - in1) : (in0 + in1);
    zero = (out == '0) && !reset;
    pos  = (out != '0) && !out[ALU_W-1];
  end
endmodule

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant, with wrap.
module alu_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);
  int              idx;
  logic [ID_W-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (!any_valid && req_valid[sel]) begin
        any_valid  = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_component among NUM_REQ requesters, one op in flight.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_op,
  input  logic [ALU_W*NUM_REQ-1:0] req_a,
  input  logic [ALU_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [ALU_W-1:0]         rsp_out,
  output logic                     rsp_zero,
  output logic                     rsp_pos,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output arb_state_e               dbg_state
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]              stat_ops,
  output logic [15:0]              stat_stall
`endif
);
  // Handshake: a request transfers on a rising edge where req_valid[i] && req_ready[i];
  // a response transfers on an edge where rsp_valid[rsp_id] && rsp_ready[rsp_id].
  arb_state_e       state, next_state;
  logic [ID_W-1:0]  last_grant;
  logic             op_r;
  logic [ALU_W-1:0] a_r, b_r;
  logic [ALU_W-1:0] alu_out;
  logic             alu_zero, alu_pos;
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             sel_op;
  logic [ALU_W-1:0] sel_a, sel_b;
  logic             rsp_fire;

  alu_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  alu_component u_alu (
    .reset(reset),
    .op   (op_r),
    .in0  (a_r),
    .in1  (b_r),
    .out  (alu_out),
    .zero (alu_zero),
    .pos  (alu_pos)
  );

  always_comb begin
    sel_op = 1'b0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_op = req_op[i];
        sel_a  = req_a[ALU_W*i +: ALU_W];
        sel_b  = req_b[ALU_W*i +: ALU_W];
      end
    end
  end

  assign rsp_fire  = (state == ARB_RESP) && rsp_ready[rsp_id];
  assign busy      = (state != ARB_IDLE);
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    req_ready  = '0;
    case (state)
      ARB_IDLE: if (pick_any) begin
        req_ready  = pick_grant;
        next_state = ARB_EXEC;
      end
      ARB_EXEC: next_state = ARB_RESP;
      ARB_RESP: if (rsp_fire) next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      op_r       <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      rsp_valid  <= '0;
      rsp_out    <= '0;
      rsp_zero   <= 1'b0;
      rsp_pos    <= 1'b0;
      rsp_id     <= '0;
    end else begin
      state <= next_state;
      case (state)
        ARB_IDLE: if (pick_any) begin
          op_r       <= sel_op;
          a_r        <= sel_a;
          b_r        <= sel_b;
          rsp_id     <= pick_idx;
          last_grant <= pick_idx;
        end
        ARB_EXEC: begin
          rsp_out   <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_pos   <= alu_pos;
          rsp_valid <= NUM_REQ'(1) << rsp_id;
        end
        ARB_RESP: if (rsp_fire) rsp_valid <= '0;
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (rsp_fire && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if ((|req_valid) && (req_ready == '0) && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk, reset;
  logic [1:0]  req_valid, req_op, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] rsp_out;
  logic        rsp_zero, rsp_pos, busy;
  logic [0:0]  rsp_id;
  arb_state_e  dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops, stat_stall;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int m_last;
  int m_ops;
  logic [15:0] exp_q[$];

  alu_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_pos(rsp_pos),
    .rsp_id(rsp_id), .busy(busy), .dbg_state(dbg_state)
`ifdef ALU_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_req(input int id, input logic op, input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin
      req_valid[0] = 1'b1; req_op[0] = op; req_a[15:0] = a; req_b[15:0] = b;
    end else begin
      req_valid[1] = 1'b1; req_op[1] = op; req_a[31:16] = a; req_b[31:16] = b;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    cycle();
    cycle();
    reset = 1'b0;
    m_last = 1;
    m_ops = 0;
  endtask

  // reference model
  function automatic int model_pick(input logic [1:0] v);
    int idx;
    for (int k = 1; k <= 2; k++) begin
      idx = (m_last + k) % 2;
      if (v[idx[0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_res(input logic op, input logic [15:0] a, input logic [15:0] b);
    return op ? (a - b) : (a + b);
  endfunction

  function automatic logic [20:0] model_rsp(input int w, input logic [15:0] r);
    logic [1:0] one;
    one = 2'(1 << w);
    return {one, w[0], r, r == 16'h0, (r != 16'h0) && !r[15]};
  endfunction

  task automatic test_reset();
    logic [22:0] got;
    got = {rsp_valid, rsp_out, rsp_zero, rsp_pos, rsp_id, busy, req_ready};
    total_cnt++;
    if (got !== 23'h0) $display("FAIL reset_outputs: got %h want %h", got, 23'h0);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== ARB_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ARB_IDLE);
    else pass_cnt++;
`ifdef ALU_ARB_STATS_EN
    total_cnt++;
    if ({stat_ops, stat_stall} !== 32'h0) $display("FAIL reset_stats: got %h want 0", {stat_ops, stat_stall});
    else pass_cnt++;
`endif
  endtask

  task automatic test_arith(input string name, input logic op, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_out, input logic exp_zero, input logic exp_pos);
    logic [20:0] got, want;
    drive_req(0, op, a, b);
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL %s_ready: got %b want 01", name, req_ready);
    else pass_cnt++;
    cycle();
    req_valid = '0;
    m_last = 0;
    total_cnt++;
    if ({busy, rsp_valid} !== 3'b100) $display("FAIL %s_exec: got %b want 100", name, {busy, rsp_valid});
    else pass_cnt++;
    cycle();
    got  = {rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_pos};
    want = {2'b01, 1'b0, exp_out, exp_zero, exp_pos};
    total_cnt++;
    if (got !== want) $display("FAIL %s_rsp: got %h want %h", name, got, want);
    else pass_cnt++;
    rsp_ready = 2'b01;
    cycle();
    rsp_ready = '0;
    m_ops++;
    total_cnt++;
    if ({busy, rsp_valid} !== 3'b000) $display("FAIL %s_done: got %b want 000", name, {busy, rsp_valid});
    else pass_cnt++;
  endtask

  task automatic test_single_add();
    test_arith("add", ALU_OP_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    test_arith("sub_zero", ALU_OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0);
    test_arith("sub_neg", ALU_OP_SUB, 16'h0002, 16'h0005, 16'hFFFD, 1'b0, 1'b0);
    test_arith("sub_ovf", ALU_OP_SUB, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    test_arith("add_wrap", ALU_OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
`ifdef ALU_ARB_STATS_EN
    total_cnt++;
    if (stat_ops !== 16'(m_ops)) $display("FAIL stat_ops_wrap: got %0d want %0d", stat_ops, m_ops);
    else pass_cnt++;
`endif
  endtask

  task automatic test_backpressure();
    logic [21:0] held;
    int bad;
    drive_req(1, ALU_OP_SUB, 16'h1234, 16'h0034);
    #1;
    total_cnt++;
    if (req_ready !== 2'b10) $display("FAIL bp_ready: got %b want 10", req_ready);
    else pass_cnt++;
    cycle();
    req_valid = '0;
    m_last = 1;
    cycle();
    drive_req(0, ALU_OP_ADD, 16'h1111, 16'h2222);
    rsp_ready = 2'b01;
    bad = 0;
    held = 22'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      held = {rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_pos, busy};
      if (held !== {2'b10, 1'b1, 16'h1200, 1'b0, 1'b1, 1'b1} || req_ready !== 2'b00) bad++;
      cycle();
    end
    total_cnt++;
    if (bad != 0) $display("FAIL bp_hold: got %h want %h (bad cycles %0d)", held, {2'b10, 1'b1, 16'h1200, 1'b0, 1'b1, 1'b1}, bad);
    else pass_cnt++;
    req_valid = '0;
    rsp_ready = 2'b10;
    cycle();
    rsp_ready = '0;
    m_ops++;
    total_cnt++;
    if ({busy, rsp_valid} !== 3'b000) $display("FAIL bp_release: got %b want 000", {busy, rsp_valid});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_resp();
    logic [21:0] got;
    drive_req(0, ALU_OP_ADD, 16'h0007, 16'h0008);
    cycle();
    req_valid = '0;
    cycle();
    do_reset();
    got = {rsp_valid, rsp_out, rsp_zero, rsp_pos, rsp_id, busy};
    total_cnt++;
    if (got !== 22'h0) $display("FAIL reset_mid_resp: got %h want %h", got, 22'h0);
    else pass_cnt++;
    rsp_ready = 2'b11;
    cycle();
    rsp_ready = '0;
    total_cnt++;
    if ({rsp_valid, busy} !== 3'b000) $display("FAIL reset_no_deliver: got %b want 000", {rsp_valid, busy});
    else pass_cnt++;
  endtask

  task automatic test_contention();
    int w;
    int grants[2];
    logic [15:0] e;
    logic [20:0] got;
    grants[0] = 0;
    grants[1] = 0;
    for (int n = 0; n < 4; n++) begin
      drive_req(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      drive_req(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      #1;
      w = model_pick(2'b11);
      total_cnt++;
      if (req_ready !== 2'(1 << w)) $display("FAIL cont_grant%0d: got %b want %b", n, req_ready, 2'(1 << w));
      else pass_cnt++;
      e = (w == 0) ? model_res(req_op[0], req_a[15:0], req_b[15:0])
                   : model_res(req_op[1], req_a[31:16], req_b[31:16]);
      exp_q.push_back(e);
      m_last = w;
      grants[w]++;
      cycle();
      cycle();
      got = {rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_pos};
      total_cnt++;
      if (got !== model_rsp(w, exp_q[0])) $display("FAIL cont_rsp%0d: got %h want %h", n, got, model_rsp(w, exp_q[0]));
      else pass_cnt++;
      void'(exp_q.pop_front());
      rsp_ready = 2'b11;
      cycle();
      rsp_ready = '0;
      m_ops++;
    end
    req_valid = '0;
    total_cnt++;
    if (grants[0] != 2 || grants[1] != 2) $display("FAIL cont_fairness: got %0d/%0d want 2/2", grants[0], grants[1]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int w, d, bad;
    logic [1:0] mask;
    logic [20:0] got, want;
    bad = 0;
    got = '0;
    want = '0;
    for (int n = 0; n < 40; n++) begin
      mask = 2'($urandom_range(0, 3));
      req_valid = '0;
      if (mask[0]) drive_req(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      if (mask[1]) drive_req(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      #1;
      w = model_pick(mask);
      if (w < 0) begin
        if (req_ready !== 2'b00 || busy !== 1'b0) bad++;
        cycle();
        continue;
      end
      if (req_ready !== 2'(1 << w)) bad++;
      exp_q.push_back((w == 0) ? model_res(req_op[0], req_a[15:0], req_b[15:0])
                               : model_res(req_op[1], req_a[31:16], req_b[31:16]));
      m_last = w;
      cycle();
      req_valid = '0;
      cycle();
      want = model_rsp(w, exp_q.pop_front());
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        rsp_ready = 2'(1 << (1 - w));
        got = {rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_pos};
        if (got !== want) bad++;
        cycle();
      end
      got = {rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_pos};
      if (got !== want) bad++;
      rsp_ready = 2'(1 << w) | 2'($urandom_range(0, 3));
      cycle();
      rsp_ready = '0;
      m_ops++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL random_traffic: %0d bad samples, last got %h want %h", bad, got, want);
    else pass_cnt++;
`ifdef ALU_ARB_STATS_EN
    total_cnt++;
    if (stat_ops !== 16'(m_ops)) $display("FAIL stat_ops_random: got %0d want %0d", stat_ops, m_ops);
    else pass_cnt++;
`endif
  endtask

  initial begin
    req_op = '0;
    req_a = '0;
    req_b = '0;
    do_reset();
    test_reset();
    test_single_add();
    test_sub();
    test_wrap();
    test_backpressure();
    test_reset_mid_resp();
    test_contention();
    test_random();
    $display("completed handshakes since last reset: %0d", m_ops);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
